chord_song_reader: RTL and testbench

- Producer side of the note/duration handshake consumed by the three-voice chord player.
- Walks a song ROM and issues notes to the chord player whenever a voice is free (player_ready).
- Advance entries stall issuance for a counted number of beats, so notes issued back-to-back sound together as a chord.
- Sits between the song ROM and the chord player; driven by the top-level play/song controls.

---
 rtl/chord_song_reader.sv | 203 ++++++++++++++++++++
 tb/tb_chord_song_reader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chord_song_reader.sv
// chord_song_reader: walks a song ROM and feeds note/duration pairs to the
// three-voice chord player, pacing issuance with counted beat advances.
module chord_song_reader #(
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned IDX_BITS  = 5,
  parameter int unsigned HOLDOFF   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          beat,
  input  logic                          player_ready,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [15:0]                   rom_data,
  output logic [5:0]                    note,
  output logic [5:0]                    duration,
  output logic                          new_note,
  output logic                          song_done
);

  localparam int unsigned FIELD_W   = 6;
  // A HOLDOFF of 0 still spends one cycle in HOLD so the state is never skipped.
  localparam int unsigned HOLD_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam int unsigned HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HOLD,
    S_WAIT_BEAT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [SONG_BITS-1:0] song_q;
  logic [IDX_BITS-1:0]  idx_q;
  logic [FIELD_W-1:0]   beat_cnt_q;
  logic [HOLD_W-1:0]    hold_cnt_q;

  logic                 song_chg;
  logic                 latch_song;
  logic                 clr_idx;
  logic                 inc_idx;
  logic                 load_entry;
  logic                 load_beat;
  logic                 dec_beat;
  logic                 clr_hold;
  logic                 inc_hold;

  // ROM entry fields
  logic                 ent_adv;
  logic [FIELD_W-1:0]   ent_note;
  logic [FIELD_W-1:0]   ent_dur;
  logic                 ent_end;
  logic                 unused_rom_bits;

  assign ent_adv         = rom_data[15];
  assign ent_note        = rom_data[14:9];
  assign ent_dur         = rom_data[8:3];
  assign ent_end         = (rom_data == 16'h0000);
  assign unused_rom_bits = ^rom_data[2:0];

  // ROM address always reflects the latched song and current entry index
  assign rom_addr = {song_q, idx_q};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; pause freezes everything, song change wins
  always_comb begin
    state_d    = state_q;
    song_chg   = 1'b0;
    latch_song = 1'b0;
    clr_idx    = 1'b0;
    inc_idx    = 1'b0;
    load_entry = 1'b0;
    load_beat  = 1'b0;
    dec_beat   = 1'b0;
    clr_hold   = 1'b0;
    inc_hold   = 1'b0;
    new_note   = 1'b0;

    if (play && !reset) begin
      song_chg = (state_q != S_IDLE) && (song != song_q);
      if (song_chg) begin
        latch_song = 1'b1;
        clr_idx    = 1'b1;
        clr_hold   = 1'b1;
        state_d    = S_FETCH;
      end else begin
        case (state_q)
          S_IDLE: begin
            latch_song = 1'b1;
            state_d    = S_FETCH;
          end
          S_FETCH: begin
            state_d = S_DECODE;
          end
          S_DECODE: begin
            if (ent_end) begin
              state_d = S_DONE;
            end else if (ent_adv) begin
              load_beat = 1'b1;
              state_d   = (ent_dur == '0) ? S_NEXT : S_WAIT_BEAT;
            end else begin
              load_entry = 1'b1;
              state_d    = S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (player_ready) begin
              new_note = 1'b1;
              clr_hold = 1'b1;
              state_d  = S_HOLD;
            end
          end
          S_HOLD: begin
            if (hold_cnt_q == HOLD_W'(HOLD_LAST)) begin
              state_d = S_NEXT;
            end else begin
              inc_hold = 1'b1;
            end
          end
          S_WAIT_BEAT: begin
            if (beat) begin
              dec_beat = 1'b1;
              if (beat_cnt_q <= FIELD_W'(1)) begin
                state_d = S_NEXT;
              end
            end
          end
          S_NEXT: begin
            if (&idx_q) begin
              state_d = S_DONE;
            end else begin
              inc_idx = 1'b1;
              state_d = S_FETCH;
            end
          end
          S_DONE: begin
            state_d = S_DONE;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  // Datapath registers: song latch, entry index, note payload, counters, done flag
  always_ff @(posedge clk) begin
    if (reset) begin
      song_q     <= song;
      idx_q      <= '0;
      note       <= '0;
      duration   <= '0;
      beat_cnt_q <= '0;
      hold_cnt_q <= '0;
      song_done  <= 1'b0;
    end else begin
      if (latch_song) begin
        song_q <= song;
      end

      if (clr_idx) begin
        idx_q <= '0;
      end else if (inc_idx) begin
        idx_q <= idx_q + IDX_BITS'(1);
      end

      if (load_entry) begin
        note     <= ent_note;
        duration <= ent_dur;
      end

      if (load_beat) begin
        beat_cnt_q <= ent_dur;
      end else if (dec_beat) begin
        beat_cnt_q <= beat_cnt_q - FIELD_W'(1);
      end

      if (clr_hold) begin
        hold_cnt_q <= '0;
      end else if (inc_hold) begin
        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      end

      song_done <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_chord_song_reader.sv
// tb_chord_song_reader: table vectors, directed corner sequences and a
// randomized run scored against a transaction-level song model.
module tb_chord_song_reader;

  localparam int unsigned SONG_BITS = 2;
  localparam int unsigned IDX_BITS  = 5;
  localparam int unsigned HOLDOFF   = 2;
  localparam int unsigned AW        = SONG_BITS + IDX_BITS;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 play;
  logic [SONG_BITS-1:0] song;
  logic                 beat;
  logic                 player_ready;
  logic [AW-1:0]        rom_addr;
  logic [15:0]          rom_data;
  logic [5:0]           note;
  logic [5:0]           duration;
  logic                 new_note;
  logic                 song_done;

  logic [15:0] rom [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    logic [5:0] note;
    logic [5:0] dur;
  } pulse_t;
  pulse_t pulses[$];

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e1;
    bit          beats;
    int          n_pulse;
    int          note0;
    int          dur0;
    bit          done;
  } vec_t;
  vec_t vecs[7];

  chord_song_reader #(
    .SONG_BITS(SONG_BITS),
    .IDX_BITS (IDX_BITS),
    .HOLDOFF  (HOLDOFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .play        (play),
    .song        (song),
    .beat        (beat),
    .player_ready(player_ready),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .note        (note),
    .duration    (duration),
    .new_note    (new_note),
    .song_done   (song_done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  // Pulse recorder, sampled mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (new_note === 1'b1) pulses.push_back('{cyc, note, duration});
  end

  function automatic logic [15:0] n_ent(int n, int d);
    return {1'b0, 6'(n), 6'(d), 3'b000};
  endfunction

  function automatic logic [15:0] a_ent(int d);
    return {1'b1, 6'd0, 6'(d), 3'b000};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    play = 1'b0;
    beat = 1'b0;
    player_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    pulses.delete();
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 16'h0000;
  endtask

  task automatic give_beat();
    beat = 1'b1;
    step();
    beat = 1'b0;
    step();
  endtask

  task automatic wait_pulses(int n, int budget, string name);
    int k = 0;
    while (pulses.size() < n && k < budget) begin
      step();
      k++;
    end
    if (pulses.size() < n) check(name, pulses.size(), n);
  endtask

  // Randomized song walk scored against the expected issue list
  task automatic random_song(int iter);
    int base = 64;
    int end_pos;
    logic [5:0] exp_n[$];
    logic [5:0] exp_d[$];
    int exp_need[$];
    int need = 0;
    int beats_since = 0;
    int last = -100;
    int k = 0;
    logic [15:0] e;

    end_pos = $urandom_range(4, 32);
    for (int i = 0; i < 32; i++) begin
      if (i == end_pos) rom[base+i] = 16'h0000;
      else if ($urandom_range(0, 3) == 0) rom[base+i] = a_ent($urandom_range(0, 3));
      else rom[base+i] = n_ent($urandom_range(1, 63), $urandom_range(0, 63));
    end
    for (int i = 0; i < 32; i++) begin
      e = rom[base+i];
      if (e == 16'h0000) break;
      if (e[15]) need += int'(e[8:3]);
      else begin
        exp_n.push_back(e[14:9]);
        exp_d.push_back(e[8:3]);
        exp_need.push_back(need);
        need = 0;
      end
    end

    song = 2'd2;
    do_reset();
    while (k < 4000) begin
      play = ($urandom_range(0, 7) != 0);
      player_ready = ($urandom_range(0, 2) != 0);
      beat = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (song_done === 1'b1) break;
      if (new_note === 1'b1) begin
        check($sformatf("rnd%0d_handshake", iter), {play, player_ready}, 2'b11);
        if (exp_n.size() == 0) check($sformatf("rnd%0d_extra_pulse", iter), 1, 0);
        else begin
          check($sformatf("rnd%0d_note", iter), note, exp_n.pop_front());
          check($sformatf("rnd%0d_dur", iter), duration, exp_d.pop_front());
          check($sformatf("rnd%0d_beats", iter), beats_since >= exp_need.pop_front(), 1);
        end
        if (last >= 0) check($sformatf("rnd%0d_gap", iter), (k - last) >= int'(HOLDOFF + 3), 1);
        last = k;
        beats_since = 0;
      end else if (beat && play) begin
        beats_since++;
      end
      step();
      k++;
    end
    beat = 1'b0;
    check($sformatf("rnd%0d_done", iter), song_done, 1);
    check($sformatf("rnd%0d_left", iter), exp_n.size(), 0);
    check($sformatf("rnd%0d_tail_beats", iter), beats_since >= need, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int c0;

    vecs[0] = '{n_ent(5, 3),   16'h0000,   1'b1, 1, 5,  3,  1'b1};
    vecs[1] = '{16'h0000,      n_ent(9, 1), 1'b1, 0, 0,  0,  1'b1};
    vecs[2] = '{a_ent(0),      n_ent(7, 2), 1'b0, 1, 7,  2,  1'b1};
    vecs[3] = '{a_ent(3),      n_ent(8, 1), 1'b1, 1, 8,  1,  1'b1};
    vecs[4] = '{a_ent(3),      n_ent(8, 1), 1'b0, 0, 0,  0,  1'b0};
    vecs[5] = '{n_ent(63, 63), n_ent(1, 0), 1'b1, 2, 63, 63, 1'b1};
    vecs[6] = '{16'h0007,      16'h0000,    1'b1, 1, 0,  0,  1'b1};

    // Reset state
    clear_rom();
    song = 2'd1;
    do_reset();
    check("rst_rom_addr", rom_addr, 32);
    check("rst_note", note, 0);
    check("rst_duration", duration, 0);
    check("rst_new_note", new_note, 0);
    check("rst_song_done", song_done, 0);

    // Table of two-entry songs
    for (int v = 0; v < 7; v++) begin
      clear_rom();
      rom[32] = vecs[v].e0;
      rom[33] = vecs[v].e1;
      song = 2'd1;
      do_reset();
      play = 1'b1;
      player_ready = 1'b1;
      for (int k = 0; k < 150; k++) begin
        beat = vecs[v].beats && (k % 5 == 0);
        step();
      end
      beat = 1'b0;
      check($sformatf("vec%0d_pulses", v), pulses.size(), vecs[v].n_pulse);
      if (pulses.size() > 0 && vecs[v].n_pulse > 0) begin
        check($sformatf("vec%0d_note", v), pulses[0].note, vecs[v].note0);
        check($sformatf("vec%0d_dur", v), pulses[0].dur, vecs[v].dur0);
      end
      check($sformatf("vec%0d_done", v), song_done, vecs[v].done);
    end

    // Chord of three notes then a 4-beat advance
    clear_rom();
    rom[0] = n_ent(10, 4);
    rom[1] = n_ent(14, 4);
    rom[2] = n_ent(17, 4);
    rom[3] = a_ent(4);
    song = 2'd0;
    do_reset();
    play = 1'b1;
    player_ready = 1'b1;
    wait_pulses(3, 100, "chord_timeout");
    if (pulses.size() >= 3) begin
      check("chord_note0", pulses[0].note, 10);
      check("chord_note1", pulses[1].note, 14);
      check("chord_note2", pulses[2].note, 17);
      check("chord_dur2", pulses[2].dur, 4);
      check("chord_gap01", (pulses[1].cyc - pulses[0].cyc) >= int'(HOLDOFF + 3), 1);
      check("chord_gap12", (pulses[2].cyc - pulses[1].cyc) >= int'(HOLDOFF + 3), 1);
    end
    run(20);
    check("chord_no_done_early", song_done, 0);
    repeat (3) give_beat();
    run(10);
    check("chord_done_after_3", song_done, 0);
    give_beat();
    run(6);
    check("chord_done_after_4", song_done, 1);
    check("chord_pulse_count", pulses.size(), 3);

    // Stall in ISSUE, then release
    clear_rom();
    rom[0] = n_ent(33, 5);
    song = 2'd0;
    do_reset();
    play = 1'b1;
    run(6);
    bad = 0;
    repeat (20) begin
      step();
      if (new_note !== 1'b0 || note !== 6'd33) bad++;
    end
    check("stall_quiet", bad, 0);
    player_ready = 1'b1;
    #1;
    check("stall_same_cycle", new_note, 1);
    check("stall_note", note, 33);
    check("stall_dur", duration, 5);
    step();
    check("stall_one_cycle", new_note, 0);
    run(20);
    check("stall_single_pulse", pulses.size(), 1);

    // Pause during a beat advance
    clear_rom();
    rom[0] = a_ent(4);
    rom[1] = n_ent(20, 3);
    song = 2'd0;
    do_reset();
    play = 1'b1;
    player_ready = 1'b1;
    run(6);
    repeat (2) give_beat();
    play = 1'b0;
    repeat (5) give_beat();
    run(3);
    check("pause_no_pulse", pulses.size(), 0);
    play = 1'b1;
    give_beat();
    run(10);
    check("pause_one_more_beat", pulses.size(), 0);
    c0 = cyc;
    give_beat();
    wait_pulses(1, 20, "pause_timeout");
    if (pulses.size() >= 1) begin
      check("pause_note", pulses[0].note, 20);
      check("pause_latency", (pulses[0].cyc - c0) <= 8, 1);
    end

    // Song change while in ISSUE
    clear_rom();
    rom[0]  = n_ent(11, 2);
    rom[64] = n_ent(44, 6);
    song = 2'd0;
    do_reset();
    play = 1'b1;
    run(6);
    song = 2'd2;
    player_ready = 1'b1;
    #1;
    check("chg_wins", new_note, 0);
    step();
    check("chg_rom_addr", rom_addr, 64);
    check("chg_song_done", song_done, 0);
    wait_pulses(1, 20, "chg_timeout");
    if (pulses.size() >= 1) check("chg_new_note", pulses[0].note, 44);
    run(10);
    check("chg_pulse_count", pulses.size(), 1);

    // Full 32-entry song with no end marker
    clear_rom();
    for (int i = 0; i < 32; i++) rom[96+i] = n_ent(i + 1, 1);
    song = 2'd3;
    do_reset();
    play = 1'b1;
    player_ready = 1'b1;
    wait_pulses(32, 400, "full_timeout");
    run(10);
    check("full_done", song_done, 1);
    if (pulses.size() >= 32) check("full_last_note", pulses[31].note, 32);
    run(50);
    check("full_no_wrap_pulses", pulses.size(), 32);
    check("full_rom_addr", rom_addr, 127);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("full_rst_done", song_done, 0);
    check("full_rst_addr", rom_addr, 96);

    // Reset asserted mid-ISSUE
    clear_rom();
    rom[32] = n_ent(50, 7);
    song = 2'd1;
    do_reset();
    play = 1'b1;
    run(6);
    check("midrst_pre_note", note, 50);
    reset = 1'b1;
    step();
    check("midrst_note", note, 0);
    check("midrst_duration", duration, 0);
    check("midrst_new_note", new_note, 0);
    check("midrst_song_done", song_done, 0);
    check("midrst_rom_addr", rom_addr, 32);
    reset = 1'b0;

    // Randomized songs against the model
    for (int it = 0; it < 3; it++) begin
      clear_rom();
      random_song(it);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
